// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Bundle of hazard-detection inputs and pipeline-control
//                outputs exchanged between the five-stage pipeline datapath
//                and the hazard controller.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals (direction seen from the controller, i.e. the slave modport)
//    ihit, dhit                 in   fetch / data access complete this cycle
//    dmem_req_EX_MEM            in   EX/MEM instruction issues a load or store
//    load_ID_EX                 in   ID/EX instruction is a load
//    Rt_ID_EX, Rs_IF_ID,
//    Rt_IF_ID                   in   5-bit register indices for load-use check
//    branch_taken_EX_MEM        in   control transfer resolved taken
//    halt                       in   halt flag of the MEM/WB register
//    pc_en                      out  PC update enable
//    enable_*                   out  pipeline register enables
//    flush_*                    out  pipeline register bubble insert
//    halted                     out  controller sits in its terminal state
//  Modports
//    master : datapath side (drives hazard inputs, receives controls)
//    slave  : controller side
// ============================================================================
interface pipeline_hazard_ctrl_if;
  logic       ihit;
  logic       dhit;
  logic       dmem_req_EX_MEM;
  logic       load_ID_EX;
  logic [4:0] Rt_ID_EX;
  logic [4:0] Rs_IF_ID;
  logic [4:0] Rt_IF_ID;
  logic       branch_taken_EX_MEM;
  logic       halt;

  logic       pc_en;
  logic       enable_IF_ID;
  logic       enable_ID_EX;
  logic       enable_EX_MEM;
  logic       enable_MEM_WB;
  logic       flush_IF_ID;
  logic       flush_ID_EX;
  logic       flush_EX_MEM;
  logic       flush_MEM_WB;
  logic       halted;

  modport master (
    output ihit, dhit, dmem_req_EX_MEM, load_ID_EX,
           Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX_MEM, halt,
    input  pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted
  );

  modport slave (
    input  ihit, dhit, dmem_req_EX_MEM, load_ID_EX,
           Rt_ID_EX, Rs_IF_ID, Rt_IF_ID, branch_taken_EX_MEM, halt,
    output pc_en, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
           flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, halted
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard controller for a five-stage pipeline. Stalls on data
//                cache misses (DWAIT state), load-use dependences and fetch
//                misses, squashes wrong-path work on a taken branch and parks
//                the pipeline in a terminal HALTED state.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK           in   rising-edge clock
//    nRST          in   synchronous active-low reset
//    hz            --   pipeline_hazard_ctrl_if.slave (hazard inputs,
//                       pc_en / enable_* / flush_* / halted outputs)
//    stall_cycles  out  32-bit saturating stall counter
//                       (present only when PIPE_STALL_COUNT_EN is defined)
//  Configuration macro
//    PIPE_STALL_COUNT_EN : adds the stall_cycles output and its counter.
//  Notes
//    Pipeline controls are combinational from state and inputs; only the
//    state, the halted flag and the optional counter are registered.
// ============================================================================
module pipeline_hazard_ctrl (
  input  wire logic               CLK,
  input  wire logic               nRST,
  pipeline_hazard_ctrl_if.slave   hz
`ifdef PIPE_STALL_COUNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DWAIT  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_halted;

  // hazard detection
  logic w_dmiss;
  logic w_load_use;

  // control outputs
  logic w_pc_en;
  logic w_en_if_id;
  logic w_en_id_ex;
  logic w_en_ex_mem;
  logic w_en_mem_wb;
  logic w_fl_if_id;
  logic w_fl_id_ex;
  logic w_fl_ex_mem;
  logic w_fl_mem_wb;

  assign w_dmiss = hz.dmem_req_EX_MEM & ~hz.dhit;

  // Index 0 is the hard-wired zero register, so a load targeting it never
  // produces a value anybody depends on.
  assign w_load_use = hz.load_ID_EX
                    & (hz.Rt_ID_EX != 5'd0)
                    & ((hz.Rt_ID_EX == hz.Rs_IF_ID) | (hz.Rt_ID_EX == hz.Rt_IF_ID));

  // --------------------------------------------------------------------------
  // Control outputs. The advance rules (branch > load-use > fetch miss >
  // normal) are shared between RUN and the completing cycle of DWAIT, so a
  // data miss costs no extra cycle once dhit arrives.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_en     = 1'b0;
    w_en_if_id  = 1'b0;
    w_en_id_ex  = 1'b0;
    w_en_ex_mem = 1'b0;
    w_en_mem_wb = 1'b0;
    w_fl_if_id  = 1'b0;
    w_fl_id_ex  = 1'b0;
    w_fl_ex_mem = 1'b0;
    w_fl_mem_wb = 1'b0;

    if (!nRST) begin
      // Clock a bubble into every pipeline register while in reset.
      w_en_if_id  = 1'b1;
      w_en_id_ex  = 1'b1;
      w_en_ex_mem = 1'b1;
      w_en_mem_wb = 1'b1;
      w_fl_if_id  = 1'b1;
      w_fl_id_ex  = 1'b1;
      w_fl_ex_mem = 1'b1;
      w_fl_mem_wb = 1'b1;
    end else if (((r_state == S_RUN) && !hz.halt && !w_dmiss) ||
                 ((r_state == S_DWAIT) && hz.dhit)) begin
      if (hz.branch_taken_EX_MEM) begin
        // Redirect: the three younger stages hold wrong-path work.
        w_pc_en     = 1'b1;
        w_en_if_id  = 1'b1;
        w_en_id_ex  = 1'b1;
        w_en_ex_mem = 1'b1;
        w_en_mem_wb = 1'b1;
        w_fl_if_id  = 1'b1;
        w_fl_id_ex  = 1'b1;
        w_fl_ex_mem = 1'b1;
      end else if (w_load_use) begin
        // Hold PC and IF/ID, let the load move on and bubble behind it.
        // Next cycle the bubble sits in ID/EX, so the stall ends by itself.
        w_en_id_ex  = 1'b1;
        w_en_ex_mem = 1'b1;
        w_en_mem_wb = 1'b1;
        w_fl_id_ex  = 1'b1;
      end else if (!hz.ihit) begin
        // Fetch not back yet: keep the PC, feed a bubble into decode.
        w_en_if_id  = 1'b1;
        w_en_id_ex  = 1'b1;
        w_en_ex_mem = 1'b1;
        w_en_mem_wb = 1'b1;
        w_fl_if_id  = 1'b1;
      end else begin
        w_pc_en     = 1'b1;
        w_en_if_id  = 1'b1;
        w_en_id_ex  = 1'b1;
        w_en_ex_mem = 1'b1;
        w_en_mem_wb = 1'b1;
      end
    end
    // Remaining cases (halt, data miss, DWAIT without dhit, HALTED) freeze
    // the whole pipeline with the all-zero defaults.
  end

  // --------------------------------------------------------------------------
  // Next state. Halt outranks a simultaneous data miss.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (hz.halt)       w_next_state = S_HALTED;
        else if (w_dmiss)  w_next_state = S_DWAIT;
        else               w_next_state = S_RUN;
      end
      S_DWAIT: begin
        if (hz.dhit)       w_next_state = S_RUN;
        else               w_next_state = S_DWAIT;
      end
      S_HALTED:            w_next_state = S_HALTED;
      default:             w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= S_RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == S_HALTED);
    end
  end

`ifdef PIPE_STALL_COUNT_EN
  logic [31:0] r_stall_cycles;

  // Counts every live cycle in which the PC is held; sticks at all-ones.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stall_cycles <= 32'd0;
    end else if (!w_pc_en && (r_state != S_HALTED) &&
                 (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign hz.pc_en         = w_pc_en;
  assign hz.enable_IF_ID  = w_en_if_id;
  assign hz.enable_ID_EX  = w_en_id_ex;
  assign hz.enable_EX_MEM = w_en_ex_mem;
  assign hz.enable_MEM_WB = w_en_mem_wb;
  assign hz.flush_IF_ID   = w_fl_if_id;
  assign hz.flush_ID_EX   = w_fl_id_ex;
  assign hz.flush_EX_MEM  = w_fl_ex_mem;
  assign hz.flush_MEM_WB  = w_fl_mem_wb;
  assign hz.halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl.
//                Output vector layout used in comparisons:
//                {pc_en, en IF/ID,ID/EX,EX/MEM,MEM/WB,
//                 flush IF/ID,ID/EX,EX/MEM,MEM/WB, halted}
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  pipeline_hazard_ctrl_if u_if ();

`ifdef PIPE_STALL_COUNT_EN
  logic [31:0] stall_cycles;
  pipeline_hazard_ctrl u_dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .hz           (u_if.slave),
    .stall_cycles (stall_cycles)
  );
`else
  pipeline_hazard_ctrl u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (u_if.slave)
  );
`endif

  localparam logic [9:0] C_NORM = 10'b1_1111_0000_0;
  localparam logic [9:0] C_ZERO = 10'b0_0000_0000_0;
  localparam logic [9:0] C_RST  = 10'b0_1111_1111_0;
  localparam logic [9:0] C_BR   = 10'b1_1111_1110_0;
  localparam logic [9:0] C_LU   = 10'b0_0111_0100_0;
  localparam logic [9:0] C_FM   = 10'b0_1111_1000_0;
  localparam logic [9:0] C_HLT  = 10'b0_0000_0000_1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] outs();
    return {u_if.pc_en, u_if.enable_IF_ID, u_if.enable_ID_EX, u_if.enable_EX_MEM,
            u_if.enable_MEM_WB, u_if.flush_IF_ID, u_if.flush_ID_EX,
            u_if.flush_EX_MEM, u_if.flush_MEM_WB, u_if.halted};
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are read 3 units
  // later, well away from both clock edges.
  task automatic idle_inputs();
    u_if.ihit = 1'b1; u_if.dhit = 1'b0; u_if.dmem_req_EX_MEM = 1'b0;
    u_if.load_ID_EX = 1'b0; u_if.Rt_ID_EX = 5'd0; u_if.Rs_IF_ID = 5'd0;
    u_if.Rt_IF_ID = 5'd0; u_if.branch_taken_EX_MEM = 1'b0; u_if.halt = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    next_cycle();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] o;
    nRST = 1'b0; idle_inputs();
    #3; o = outs(); total++;
    if (o[9:1] !== C_RST[9:1]) begin bad++; $display("FAIL reset_outputs: got %b required %b", o[9:1], C_RST[9:1]); end
    next_cycle(); #3; o = outs(); total++;
    if (o !== C_RST) begin bad++; $display("FAIL reset_halted: got %b required %b", o, C_RST); end
    nRST = 1'b1; #1;
`ifdef PIPE_STALL_COUNT_EN
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", stall_cycles); end
`endif
  endtask

  task automatic test_normal();
    logic [9:0] o;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #3; o = outs(); total++;
      if (o !== C_NORM) begin bad++; $display("FAIL normal_%0d: got %b required %b", i, o, C_NORM); end
      next_cycle();
    end
`ifdef PIPE_STALL_COUNT_EN
    total++;
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL normal_count: got %0d required 0", stall_cycles); end
`endif
  endtask

  task automatic test_dmiss();
    logic [9:0] o;
    do_reset();
    u_if.dmem_req_EX_MEM = 1'b1; u_if.dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3; o = outs(); total++;
      if (o !== C_ZERO) begin bad++; $display("FAIL dmiss_wait_%0d: got %b required %b", i, o, C_ZERO); end
      next_cycle();
    end
    u_if.dhit = 1'b1;
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL dmiss_release: got %b required %b", o, C_NORM); end
    next_cycle();
    // Back in RUN: a request that hits is not a miss.
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL dmiss_back_run: got %b required %b", o, C_NORM); end
`ifdef PIPE_STALL_COUNT_EN
    total++;
    if (stall_cycles !== 32'd3) begin bad++; $display("FAIL dmiss_count: got %0d required 3", stall_cycles); end
`endif
    next_cycle();
    u_if.dmem_req_EX_MEM = 1'b0; u_if.dhit = 1'b0;
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL dhit_stays_run: got %b required %b", o, C_NORM); end
  endtask

  task automatic test_load_use();
    logic [9:0] o;
    do_reset();
    u_if.load_ID_EX = 1'b1; u_if.Rt_ID_EX = 5'd5; u_if.Rs_IF_ID = 5'd5; u_if.Rt_IF_ID = 5'd9;
    #3; o = outs(); total++;
    if (o !== C_LU) begin bad++; $display("FAIL loaduse_rs: got %b required %b", o, C_LU); end
    next_cycle();
    // The load has moved on and a bubble occupies ID/EX.
    u_if.load_ID_EX = 1'b0;
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL loaduse_one_cycle: got %b required %b", o, C_NORM); end
    next_cycle();
    u_if.load_ID_EX = 1'b1; u_if.Rt_ID_EX = 5'd17; u_if.Rs_IF_ID = 5'd3; u_if.Rt_IF_ID = 5'd17;
    #3; o = outs(); total++;
    if (o !== C_LU) begin bad++; $display("FAIL loaduse_rt: got %b required %b", o, C_LU); end
    next_cycle();
    u_if.Rt_ID_EX = 5'd0; u_if.Rs_IF_ID = 5'd0; u_if.Rt_IF_ID = 5'd0;
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL loaduse_r0: got %b required %b", o, C_NORM); end
    next_cycle();
    u_if.Rt_ID_EX = 5'd4; u_if.Rs_IF_ID = 5'd5; u_if.Rt_IF_ID = 5'd6;
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL loaduse_nomatch: got %b required %b", o, C_NORM); end
    next_cycle();
    u_if.load_ID_EX = 1'b0; u_if.ihit = 1'b0;
    #3; o = outs(); total++;
    if (o !== C_FM) begin bad++; $display("FAIL fetch_miss: got %b required %b", o, C_FM); end
    next_cycle();
    u_if.load_ID_EX = 1'b1; u_if.Rt_ID_EX = 5'd6;
    #3; o = outs(); total++;
    if (o !== C_LU) begin bad++; $display("FAIL loaduse_over_fmiss: got %b required %b", o, C_LU); end
  endtask

  task automatic test_branch();
    logic [9:0] o;
    do_reset();
    u_if.branch_taken_EX_MEM = 1'b1; u_if.ihit = 1'b0;
    u_if.load_ID_EX = 1'b1; u_if.Rt_ID_EX = 5'd7; u_if.Rs_IF_ID = 5'd7;
    #3; o = outs(); total++;
    if (o !== C_BR) begin bad++; $display("FAIL branch_priority: got %b required %b", o, C_BR); end
    next_cycle();
    // Miss then completion with a branch pending: branch rules apply on dhit.
    idle_inputs();
    u_if.dmem_req_EX_MEM = 1'b1; u_if.branch_taken_EX_MEM = 1'b1;
    #3; o = outs(); total++;
    if (o !== C_ZERO) begin bad++; $display("FAIL miss_over_branch: got %b required %b", o, C_ZERO); end
    next_cycle();
    u_if.dhit = 1'b1;
    #3; o = outs(); total++;
    if (o !== C_BR) begin bad++; $display("FAIL dwait_branch: got %b required %b", o, C_BR); end
  endtask

  task automatic test_halt();
    logic [9:0] o;
    do_reset();
    u_if.halt = 1'b1;
    #3; o = outs(); total++;
    if (o !== C_ZERO) begin bad++; $display("FAIL halt_entry: got %b required %b", o, C_ZERO); end
    next_cycle();
    u_if.halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u_if.ihit = i[0]; u_if.branch_taken_EX_MEM = ~i[0];
      u_if.dmem_req_EX_MEM = 1'b1; u_if.dhit = i[1];
      #3; o = outs(); total++;
      if (o !== C_HLT) begin bad++; $display("FAIL halted_frozen_%0d: got %b required %b", i, o, C_HLT); end
      next_cycle();
    end
`ifdef PIPE_STALL_COUNT_EN
    total++;
    if (stall_cycles !== 32'd1) begin bad++; $display("FAIL halt_count: got %0d required 1", stall_cycles); end
`endif
    idle_inputs();
    nRST = 1'b0;
    #3; o = outs(); total++;
    if (o !== (C_RST | 10'b1)) begin bad++; $display("FAIL halt_reset_outs: got %b required %b", o, C_RST | 10'b1); end
    next_cycle();
    nRST = 1'b1;
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL halt_recover: got %b required %b", o, C_NORM); end
  endtask

  task automatic test_halt_vs_miss();
    logic [9:0] o;
    do_reset();
    u_if.halt = 1'b1; u_if.dmem_req_EX_MEM = 1'b1; u_if.dhit = 1'b0;
    next_cycle();
    // DWAIT would release on dhit; HALTED must not.
    u_if.halt = 1'b0; u_if.dhit = 1'b1;
    #3; o = outs(); total++;
    if (o !== C_HLT) begin bad++; $display("FAIL halt_over_miss: got %b required %b", o, C_HLT); end
  endtask

  task automatic test_reset_in_dwait();
    logic [9:0] o;
    do_reset();
    u_if.dmem_req_EX_MEM = 1'b1;
    next_cycle();
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1; idle_inputs();
    #3; o = outs(); total++;
    if (o !== C_NORM) begin bad++; $display("FAIL dwait_abandon: got %b required %b", o, C_NORM); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    idle_inputs();
    next_cycle();
    test_reset();
    test_normal();
    test_dmiss();
    test_load_use();
    test_branch();
    test_halt();
    test_halt_vs_miss();
    test_reset_in_dwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
